// File: rtl/clint_timer.sv
`default_nettype none
// ============================================================================
// Module   : clint_timer
// Purpose  : RISC-V style machine timer with an Avalon-MM register window.
//            64-bit mtime advanced by a prescaled tick, 64-bit mtimecmp,
//            ctrl register (bit0 enable RW, bit1 pending RO) and a
//            registered level interrupt timer_irq = enable & (mtime >= mtimecmp).
//            Register map (byte offsets from BASE):
//              0x00 mtime_lo   0x04 mtime_hi (shadow)   0x08 mtimecmp_lo
//              0x0C mtimecmp_hi  0x10 ctrl   0x14-0x1C reserved (read 0)
// Ports    : clk, rst (async, active-high)
//            address[31:0], read, write, writedata[31:0], byteenable[3:0]
//            waitrequest (always 0), readdata[31:0], readdatavalid
//            timer_irq (level, registered)
// Revision : 1.0 - initial release
// ============================================================================
module clint_timer #(
  parameter logic [31:0] BASE     = 32'h0000_4000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        timer_irq
);

  localparam logic [15:0] c_PRESCALE_MAX = 16'(PRESCALE - 32'd1);

  logic [15:0] presc_q,    presc_d;
  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        enable_q,   enable_d;
  logic [31:0] shadow_q,   shadow_d;
  logic [31:0] rdata_q,    rdata_d;
  logic        rvalid_q,   rvalid_d;
  logic        irq_q,      irq_d;

  // Address decode: subtracting BASE makes addresses below BASE wrap to a
  // large offset, so one upper-bits test covers both window edges.
  logic [31:0] w_offset;
  logic        w_in_win;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic        w_unused_ok;

  assign w_offset    = address - BASE;
  assign w_in_win    = (w_offset[31:5] == 27'd0);
  assign w_idx       = w_offset[4:2];
  assign w_wr        = write && w_in_win;
  assign w_rd        = read && !write;   // a simultaneous write suppresses the read
  assign w_tick      = enable_q && (presc_q == c_PRESCALE_MAX);
  assign w_unused_ok = &{1'b0, w_offset[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    presc_d    = presc_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    enable_d   = enable_q;
    shadow_d   = shadow_q;
    rdata_d    = 32'd0;
    rvalid_d   = w_rd;

    if (enable_q) presc_d = w_tick ? 16'd0 : presc_q + 16'd1;

    // A write to either mtime half takes priority over the tick; the whole
    // increment (including any carry into the other half) is dropped.
    if (w_wr && w_idx == 3'd0) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], writedata, byteenable);
    end else if (w_wr && w_idx == 3'd1) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], writedata, byteenable);
    end else if (w_tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (w_wr && w_idx == 3'd2) mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], writedata, byteenable);
    if (w_wr && w_idx == 3'd3) mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], writedata, byteenable);
    if (w_wr && w_idx == 3'd4 && byteenable[0]) enable_d = writedata[0];

    // Read data comes from the pre-update register values.
    if (w_rd && w_in_win) begin
      case (w_idx)
        3'd0: begin
          rdata_d  = mtime_q[31:0];
          shadow_d = mtime_q[63:32];   // latch hi for an atomic lo-then-hi read
        end
        3'd1:    rdata_d = shadow_q;
        3'd2:    rdata_d = mtimecmp_q[31:0];
        3'd3:    rdata_d = mtimecmp_q[63:32];
        3'd4:    rdata_d = {30'd0, irq_q, enable_q};
        default: rdata_d = 32'd0;
      endcase
    end

    irq_d = enable_q && (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      enable_q   <= 1'b1;
      shadow_q   <= 32'd0;
      rdata_q    <= 32'd0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      enable_q   <= enable_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign waitrequest   = 1'b0;
  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;
  assign timer_irq     = irq_q;

endmodule
`default_nettype wire

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_4000: byte base address of the 32-byte register window.
REQ-002 SHALL have parameter PRESCALE, default 1: number of clk cycles per mtime increment, legal range 1..65535.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port address  input  32: Avalon-MM agent byte address, word aligned.
REQ-006 SHALL have port read  input  1: read request.
REQ-007 SHALL have port write  input  1: write request.
REQ-008 SHALL have port writedata  input  32: write data.
REQ-009 SHALL have port byteenable  input  4: per-byte write enables.
REQ-010 SHALL have port waitrequest  output  1: always 0; every access is accepted in its request cycle.
REQ-011 SHALL have port readdata  output  32: read data, valid while readdatavalid=1.
REQ-012 SHALL have port readdatavalid  output  1: one-cycle pulse per accepted read.
REQ-013 SHALL have port timer_irq  output  1: machine timer interrupt, level, registered.

Function
REQ-014 SHALL decode offsets relative to BASE: 0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo, 0x0C mtimecmp_hi, 0x10 ctrl; 0x14-0x1C reserved; all other addresses are outside the window.
REQ-015 SHALL define ctrl as bit0 enable (RW) and bit1 pending (RO, equals timer_irq); other bits read 0.
REQ-016 SHALL keep a 16-bit prescaler counting 0..PRESCALE-1 while enable=1, wrapping to 0 and generating a tick on the cycle it equals PRESCALE-1.
REQ-017 SHALL hold the prescaler and mtime constant while enable=0.
REQ-018 SHALL increment the 64-bit mtime by 1 on each tick, wrapping from 2^64-1 to 0.
REQ-019 SHALL, on a write to mtime_lo/mtime_hi, apply only enabled bytes to that half; a write in a tick cycle wins and the increment is dropped for that cycle.
REQ-020 SHALL, on a write to mtime_lo with a tick and a carry into the high half, leave mtime_hi unchanged by the increment.
REQ-021 SHALL apply byte-enabled writes to mtimecmp halves and ctrl bit0 in the request cycle.
REQ-022 SHALL return read data exactly 1 cycle after the request cycle, asserting readdatavalid for that single cycle.
REQ-023 SHALL sample read data from register values before any same-cycle update.
REQ-024 SHALL, when mtime_lo is read, copy mtime_hi into a 32-bit shadow register in the same cycle.
REQ-025 SHALL return the shadow for mtime_hi reads, giving software an atomic 64-bit read in lo-then-hi order.
REQ-026 SHALL return 0 for reads of reserved or out-of-window addresses with readdatavalid still pulsed.
REQ-027 SHALL ignore writes to reserved, read-only or out-of-window locations.
REQ-028 SHALL perform only the write when read and write are asserted together, with no readdatavalid pulse.
REQ-029 SHALL register timer_irq = enable AND (mtime >= mtimecmp, unsigned 64-bit), so it reflects register state one cycle later.
REQ-030 SHALL raise no interrupt from mtime wrap alone; comparison is purely unsigned.

Reset
REQ-031 SHALL, while rst=1 and independent of clk, force mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, enable=1, prescaler=0, shadow=0, readdata=0, readdatavalid=0, timer_irq=0.
REQ-032 SHALL abort a pending read response when reset asserts mid-operation; no readdatavalid follows release.
REQ-033 SHALL start counting on the first rising edge after rst deasserts.

Verification
REQ-034 SHALL be verified: PRESCALE=4, release reset, wait 40 cycles, read 0x00 -> readdata=10 one cycle later with readdatavalid high for exactly 1 cycle.
REQ-035 SHALL be verified: write mtime={32'h0,32'hFFFF_FFFF}, PRESCALE=1; read lo, wait 5 cycles, read hi -> lo=32'hFFFF_FFFF+k, hi=0 from shadow although live hi=1.
REQ-036 SHALL be verified: write mtimecmp=20, mtime=0, PRESCALE=1 -> timer_irq rises 1 cycle after mtime reaches 20; ctrl read shows 0x3; write ctrl=0 -> timer_irq low next cycle, mtime frozen.
REQ-037 SHALL be verified: write 0x08 with byteenable=4'b0010, writedata=32'hAABBCCDD -> mtimecmp_lo=32'hFFFFCCFF.
REQ-038 SHALL be verified: read BASE+0x40 -> readdata=0, readdatavalid pulse; read+write together to 0x10 -> write applied, no readdatavalid.
REQ-039 SHALL be verified: assert rst in the cycle after a read request -> readdatavalid stays 0 and all outputs show reset values until release.
